// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, req/valid instruction fetch and valid/ready issue to decode, with BEQ stall.
// Optional IFU_PERF_CNT_EN adds FetchCnt/StallCnt performance counters.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 2
) (
`ifdef IFU_PERF_CNT_EN
    output logic [15:0]       FetchCnt,
    output logic [15:0]       StallCnt,
`endif
    input  logic              clk,
    input  logic              rstn,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic [15:0]       ImemRdata,
    input  logic              ImemValid,
    output logic [15:0]       Instr,
    output logic [2:0]        Opcode,
    output logic [ADDR_W-1:0] InstrPc,
    output logic              InstrValid,
    input  logic              InstrReady,
    input  logic              BrResolve,
    input  logic              BrTaken
);
    typedef enum logic [1:0] {FETCH, WAIT, ISSUE, BRWAIT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, seq_pc, br_off;
    logic              cap;

    assign seq_pc     = InstrPc + ADDR_W'(PC_STEP);
    assign br_off     = ADDR_W'({{(ADDR_W-7){Instr[6]}}, Instr[6:0]}) << 1;
    assign cap        = state == WAIT && ImemValid;
    // Request is gated by rstn so it is low for the whole reset window.
    assign ImemReq    = rstn && (state == FETCH || state == WAIT);
    assign ImemAddr   = pc;
    assign InstrValid = state == ISSUE;
    assign Opcode     = Instr[15:13];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            FETCH:  state_nxt = WAIT;
            WAIT:   state_nxt = ImemValid ? ISSUE : WAIT;
            ISSUE: if (InstrReady) begin
                state_nxt = Opcode == 3'b011 ? BRWAIT : FETCH;
                pc_nxt    = Opcode == 3'b011 ? pc : seq_pc;
            end
            BRWAIT: if (BrResolve) begin
                state_nxt = FETCH;
                pc_nxt    = seq_pc + (BrTaken ? br_off : '0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            Instr   <= '0;
            InstrPc <= '0;
        end else if (cap) begin
            Instr   <= ImemRdata;
            InstrPc <= pc;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic stall;
    assign stall = state == WAIT || state == BRWAIT || (state == ISSUE && !InstrReady);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            FetchCnt <= '0;
            StallCnt <= '0;
        end else begin
            FetchCnt <= FetchCnt + {15'd0, state == ISSUE && InstrReady};
            StallCnt <= StallCnt + {15'd0, stall};
        end
    end
`endif
endmodule
